// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle sequencer
package mc_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] ASRC_REG    = 2'b00;
    localparam logic [1:0] ASRC_IMM    = 2'b01;
    localparam logic [1:0] ASRC_PC_IMM = 2'b11;

    typedef struct packed {
        logic [1:0] alu_src;
        logic [2:0] imm_src;
        logic [2:0] alu_select;
        logic       sub_arith;
        logic       alu_result_src;
        logic       result_src;
        logic       pc_src;
        logic       reg_write;
        logic       mem;
        logic       store;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - instruction/data memory handshake bundle
interface mc_sequencer_if;
    logic [31:0] Instr;
    logic        IReady;
    logic        DReady;
    logic        IReq;
    logic        DReq;
    logic        DWrite;

    modport master (input Instr, IReady, DReady, output IReq, DReq, DWrite);
    modport slave  (output Instr, IReady, DReady, input IReq, DReq, DWrite);
endinterface

// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - combinational decode of the latched instruction
module mc_maindec
    import mc_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        eq,
    input  logic        lt,
    input  logic        ltu,
    output ctrl_t       ctrl
);

    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_slt;
    logic       taken;
    logic       unused_ir_bits;

    assign funct3         = ir[14:12];
    assign funct7_5       = ir[30];
    assign is_slt         = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (ir[6:0])
            OP_REG: begin
                ctrl.alu_src    = ASRC_REG;
                ctrl.alu_select = funct3;
                ctrl.reg_write  = 1'b1;
                // add/sub and srl/sra share funct3; bit 30 picks the variant
                ctrl.sub_arith  = (funct3 == 3'b000 || funct3 == 3'b101) ? funct7_5 : is_slt;
            end
            OP_IMM: begin
                ctrl.alu_src    = ASRC_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_select = funct3;
                ctrl.reg_write  = 1'b1;
                ctrl.sub_arith  = (funct3 == 3'b101) ? funct7_5 : is_slt;
            end
            OP_LOAD: begin
                ctrl.alu_src    = ASRC_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem        = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_src = ASRC_IMM;
                ctrl.imm_src = IMM_S;
                ctrl.mem     = 1'b1;
                ctrl.store   = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_src = ASRC_PC_IMM;
                ctrl.imm_src = IMM_B;
                ctrl.pc_src  = taken;
                ctrl.illegal = (funct3[2:1] == 2'b01);
            end
            OP_JAL: begin
                ctrl.alu_src        = ASRC_PC_IMM;
                ctrl.imm_src        = IMM_J;
                ctrl.pc_src         = 1'b1;
                ctrl.alu_result_src = 1'b1;
                ctrl.reg_write      = 1'b1;
            end
            OP_JALR: begin
                ctrl.alu_src        = ASRC_IMM;
                ctrl.imm_src        = IMM_I;
                ctrl.pc_src         = 1'b1;
                ctrl.alu_result_src = 1'b1;
                ctrl.reg_write      = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle fetch/execute/memory control FSM
module mc_sequencer
    import mc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mc_sequencer_if.master        bus,
    input  logic                  Eq,
    input  logic                  LT,
    input  logic                  LTU,
    output logic                  InstrEn,
    output logic                  PCEn,
    output logic                  PCSrc,
    output logic [1:0]            ALUSrc,
    output logic [2:0]            ImmSrc,
    output logic [2:0]            ALUSelect,
    output logic                  SubArith,
    output logic                  ALUResultSrc,
    output logic                  ResultSrc,
    output logic                  RegWrite,
    output logic                  Illegal
);

    state_t      state, next_state;
    logic [31:0] ir;
    ctrl_t       ctrl;
    logic        ireq, dreq, dwrite, drive;

    mc_maindec u_maindec (
        .ir   (ir),
        .eq   (Eq),
        .lt   (LT),
        .ltu  (LTU),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (InstrEn) begin
            ir <= bus.Instr;
        end
    end

    always_comb begin
        next_state = state;
        ireq       = 1'b0;
        dreq       = 1'b0;
        dwrite     = 1'b0;
        drive      = 1'b0;
        InstrEn    = 1'b0;
        PCEn       = 1'b0;
        RegWrite   = 1'b0;
        Illegal    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ireq = 1'b1;
                    if (bus.IReady) begin
                        InstrEn    = 1'b1;
                        next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ctrl.illegal) begin
                        next_state = S_TRAP;
                    end else if (ctrl.mem) begin
                        drive      = 1'b1;
                        dreq       = 1'b1;
                        dwrite     = ctrl.store;
                        next_state = S_MEM;
                    end else begin
                        drive      = 1'b1;
                        PCEn       = 1'b1;
                        RegWrite   = ctrl.reg_write;
                        next_state = S_FETCH;
                    end
                end
                S_MEM: begin
                    // controls are held from EXEC so the address stays valid while waiting
                    drive  = 1'b1;
                    dreq   = 1'b1;
                    dwrite = ctrl.store;
                    if (bus.DReady) begin
                        PCEn       = 1'b1;
                        RegWrite   = ctrl.reg_write;
                        next_state = S_FETCH;
                    end
                end
                S_TRAP: begin
                    Illegal = 1'b1;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign bus.IReq     = ireq;
    assign bus.DReq     = dreq;
    assign bus.DWrite   = dwrite;
    assign ALUSrc       = drive ? ctrl.alu_src        : 2'b00;
    assign ImmSrc       = drive ? ctrl.imm_src        : 3'b000;
    assign ALUSelect    = drive ? ctrl.alu_select     : 3'b000;
    assign SubArith     = drive ? ctrl.sub_arith      : 1'b0;
    assign ALUResultSrc = drive ? ctrl.alu_result_src : 1'b0;
    assign ResultSrc    = drive ? ctrl.result_src     : 1'b0;
    assign PCSrc        = drive ? ctrl.pc_src         : 1'b0;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - scoreboard bench for mc_sequencer
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       Eq, LT, LTU;
    logic       InstrEn, PCEn, PCSrc, SubArith, ALUResultSrc, ResultSrc, RegWrite, Illegal;
    logic [1:0] ALUSrc;
    logic [2:0] ImmSrc, ALUSelect;

    mc_sequencer_if bus ();

    mc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .Eq           (Eq),
        .LT           (LT),
        .LTU          (LTU),
        .InstrEn      (InstrEn),
        .PCEn         (PCEn),
        .PCSrc        (PCSrc),
        .ALUSrc       (ALUSrc),
        .ImmSrc       (ImmSrc),
        .ALUSelect    (ALUSelect),
        .SubArith     (SubArith),
        .ALUResultSrc (ALUResultSrc),
        .ResultSrc    (ResultSrc),
        .RegWrite     (RegWrite),
        .Illegal      (Illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        bit       trap;
        bit [1:0] alu_src;
        bit       imm_chk;
        bit [2:0] imm_src;
        bit [2:0] alu_sel;
        bit       sub;
        bit       ars;
        bit       rs;
        bit       rw;
        bit       pcsrc;
        bit       dwrite;
        int       dreq_cycles;
    } exp_t;

    exp_t sb[$];

    // Reference: what the instruction should do, from its opcode/funct fields
    function automatic exp_t model(logic [31:0] ins, bit eq, bit lt, bit ltu, int ddelay);
        exp_t     e;
        bit [6:0] op     = ins[6:0];
        bit [2:0] f3     = ins[14:12];
        bit       b30    = ins[30];
        bit       is_slt = (f3 == 3'd2) || (f3 == 3'd3);
        bit [7:0] taken_tbl;
        e = '{default: 0};
        taken_tbl = {!ltu, ltu, !lt, lt, 1'b0, 1'b0, !eq, eq};
        case (op)
            7'h33: begin e.alu_sel = f3; e.rw = 1; e.sub = (f3 == 0 || f3 == 5) ? b30 : is_slt; end
            7'h13: begin e.alu_src = 1; e.imm_chk = 1; e.imm_src = 0; e.alu_sel = f3; e.rw = 1;
                         e.sub = (f3 == 5) ? b30 : is_slt; end
            7'h03: begin e.alu_src = 1; e.imm_chk = 1; e.imm_src = 0; e.rs = 1; e.rw = 1;
                         e.dreq_cycles = ddelay + 2; end
            7'h23: begin e.alu_src = 1; e.imm_chk = 1; e.imm_src = 1; e.dwrite = 1;
                         e.dreq_cycles = ddelay + 2; end
            7'h63: begin
                if (f3 == 2 || f3 == 3) e.trap = 1;
                else begin e.alu_src = 3; e.imm_chk = 1; e.imm_src = 2; e.pcsrc = taken_tbl[f3]; end
            end
            7'h6f: begin e.alu_src = 3; e.imm_chk = 1; e.imm_src = 3; e.pcsrc = 1; e.ars = 1; e.rw = 1; end
            7'h67: begin e.alu_src = 1; e.imm_chk = 1; e.imm_src = 0; e.pcsrc = 1; e.ars = 1; e.rw = 1; end
            default: e.trap = 1;
        endcase
        return e;
    endfunction

    // Monitor: pops on every retirement (PCEn) and on every entry into the trap
    int          dq_cnt = 0, stray = 0, unstable = 0;
    bit          snap_v = 0, prev_ill = 0;
    logic [13:0] snap, cur;
    exp_t        me;

    always @(negedge clk) begin
        if (reset) begin
            dq_cnt = 0; stray = 0; unstable = 0; snap_v = 0; prev_ill = 0;
        end else begin
            if (RegWrite && !PCEn) stray++;
            if (bus.DReq) begin
                cur = {bus.DWrite, ALUSrc, ImmSrc, ALUSelect, SubArith, ALUResultSrc, ResultSrc, PCSrc};
                if (snap_v && cur !== snap) unstable++;
                snap = cur; snap_v = 1; dq_cnt++;
            end
            if (PCEn) begin
                if (sb.size() == 0) begin
                    chk("retire_without_issue", sb.size(), 1);
                end else begin
                    me = sb.pop_front();
                    chk("illegal_on_retire", Illegal, me.trap);
                    chk("pcsrc", PCSrc, me.pcsrc);
                    chk("regwrite", RegWrite, me.rw);
                    chk("resultsrc", ResultSrc, me.rs);
                    chk("alusrc", ALUSrc, me.alu_src);
                    chk("aluselect", ALUSelect, me.alu_sel);
                    chk("subarith", SubArith, me.sub);
                    chk("aluresultsrc", ALUResultSrc, me.ars);
                    chk("dwrite", bus.DWrite, me.dwrite);
                    if (me.imm_chk) chk("immsrc", ImmSrc, me.imm_src);
                    chk("dreq_cycles", dq_cnt, me.dreq_cycles);
                    chk("stray_regwrite", stray, 0);
                    chk("mem_ctrl_stable", unstable, 0);
                end
                dq_cnt = 0; stray = 0; unstable = 0; snap_v = 0;
            end
            if (Illegal && !prev_ill) begin
                if (sb.size() == 0) begin
                    chk("trap_without_issue", sb.size(), 1);
                end else begin
                    me = sb.pop_front();
                    chk("illegal_vs_model", Illegal, me.trap);
                end
            end
            prev_ill = Illegal;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.IReady = 1'b0;
        bus.DReady = 1'b0;
        tick();
        chk("reset_outputs_zero",
            {InstrEn, PCEn, PCSrc, ALUSrc, ImmSrc, ALUSelect, SubArith, ALUResultSrc,
             ResultSrc, RegWrite, Illegal, bus.IReq, bus.DReq, bus.DWrite}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("ireq_after_reset", bus.IReq, 1);
    endtask

    task automatic do_instr(logic [31:0] ins, bit eq, bit lt, bit ltu, int idelay, int ddelay, bit abort);
        int   n = 0;
        exp_t e;
        while (!bus.IReq && n < 20) begin tick(); n++; end
        chk("ireq_wait", bus.IReq, 1);
        if (!bus.IReq) return;
        repeat (idelay) begin
            bus.IReady = 1'b0;
            bus.Instr  = $urandom;
            tick();
            chk("ireq_held", bus.IReq, 1);
        end
        bus.Instr  = ins;
        bus.IReady = 1'b1;
        Eq = eq; LT = lt; LTU = ltu;
        #1 chk("instren", InstrEn, 1);
        e = model(ins, eq, lt, ltu, ddelay);
        sb.push_back(e);
        tick();
        // stray handshakes while executing must not disturb anything
        bus.IReady = 1'($urandom_range(0, 1));
        bus.Instr  = $urandom;
        bus.DReady = 1'($urandom_range(0, 1));
        if (e.trap) begin
            tick();
            bus.DReady = 1'b0;
            repeat (10) begin
                bus.IReady = 1'($urandom_range(0, 1));
                chk("trap_hold", {Illegal, bus.IReq, PCEn, RegWrite, bus.DReq}, 5'b10000);
                tick();
            end
            do_reset();
        end else if (e.dreq_cycles > 0) begin
            tick();
            bus.IReady = 1'b0;
            bus.DReady = 1'b0;
            if (abort) begin
                tick();
                void'(sb.pop_back());
                do_reset();
            end else begin
                repeat (ddelay) tick();
                bus.DReady = 1'b1;
                tick();
                bus.DReady = 1'b0;
                chk("back_to_fetch", bus.IReq, 1);
            end
        end else begin
            tick();
            bus.IReady = 1'b0;
            bus.DReady = 1'b0;
            chk("back_to_fetch", bus.IReq, 1);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  op;
        case ($urandom_range(0, 9))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4, 5: op = 7'h63;
            6: op = 7'h6f;
            7: op = 7'h67;
            8: case ($urandom_range(0, 3))
                   0: op = 7'h37;
                   1: op = 7'h17;
                   2: op = 7'h0f;
                   default: op = 7'h73;
               endcase
            default: case ($urandom_range(0, 3))
                   0: op = 7'h7f;
                   1: op = 7'h0b;
                   2: op = 7'h2b;
                   default: op = 7'h5b;
               endcase
        endcase
        w[6:0] = op;
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.Instr = '0; bus.IReady = 1'b0; bus.DReady = 1'b0;
        Eq = 1'b0; LT = 1'b0; LTU = 1'b0;
        do_reset();

        do_instr(32'h002081B3, 0, 0, 0, 0, 0, 0);
        do_instr(32'h0040A283, 0, 0, 0, 1, 2, 0);
        do_instr(32'h0020A423, 0, 0, 0, 0, 1, 0);
        do_instr(32'h00000463, 1, 0, 0, 0, 0, 0);
        do_instr(32'h00000463, 0, 1, 1, 2, 0, 0);
        do_instr(32'h010000EF, 0, 0, 0, 0, 0, 0);
        do_instr(32'h0040A283, 0, 0, 0, 0, 3, 1);
        do_instr(32'h000012B7, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            do_instr(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
